// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out converter with valid/ready load and per-strobe bit readout
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] D,
  input  logic             SHIFT_EN,
  output logic             Q,
  output logic             QN,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic q_q, q_d;
  // next state: the current Q bit always sits at the output end of sreg, so a strobe shifts and exposes the next one
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    case (state_q)
      S_IDLE: begin
        q_d = 1'b0;
        if (LOAD_VALID) begin
          state_d = S_SHIFT;
          sreg_d  = D;
          cnt_d   = CNT_MAX;
          q_d     = LSB_FIRST ? D[0] : D[WIDTH-1];
        end
      end
      S_SHIFT: begin
        if (SHIFT_EN) begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
            q_d     = 1'b0;
          end else begin
            sreg_d = LSB_FIRST ? sreg_q >> 1 : sreg_q << 1;
            q_d    = LSB_FIRST ? sreg_q[1] : sreg_q[WIDTH-2];
            cnt_d  = cnt_q - CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        q_d     = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        q_d     = 1'b0;
      end
    endcase
  end
  // state registers; reset drops any partial word immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end
  assign LOAD_READY = (state_q == S_IDLE);
  assign BUSY       = (state_q == S_SHIFT);
  assign DONE       = (state_q == S_DONE);
  assign Q          = q_q;
  assign QN         = ~q_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for MSB-first and LSB-first serializers
module tb_piso_serializer;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic lv [2];
  logic sen [2];
  logic rdy [2];
  logic q [2];
  logic qn [2];
  logic busy [2];
  logic done [2];
  logic [7:0] d [2];
  bit expq [2][$];
  int ph [2];
  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ph models the expected phase: 0 idle, 1 shifting, 2 done pulse
  for (genvar g = 0; g < 2; g++) begin : g_dut
    piso_serializer #(.WIDTH(8), .LSB_FIRST(g == 1)) dut (
      .CLK(CLK), .RST_N(RST_N), .LOAD_VALID(lv[g]), .LOAD_READY(rdy[g]), .D(d[g]),
      .SHIFT_EN(sen[g]), .Q(q[g]), .QN(qn[g]), .BUSY(busy[g]), .DONE(done[g])
    );
    // monitor: checks outputs mid-cycle and pops one expected bit per consumed strobe
    always @(negedge CLK) begin
      chk($sformatf("u%0d_ready", g), rdy[g], ph[g] == 0);
      chk($sformatf("u%0d_busy", g), busy[g], ph[g] == 1);
      chk($sformatf("u%0d_done", g), done[g], ph[g] == 2);
      chk($sformatf("u%0d_qn", g), qn[g], !q[g]);
      if (ph[g] == 1) begin
        if (expq[g].size() == 0) chk($sformatf("u%0d_underflow", g), 1, 0);
        else chk($sformatf("u%0d_q_bit%0d", g, 8 - expq[g].size()), q[g], expq[g][0]);
      end else begin
        chk($sformatf("u%0d_q_idle", g), q[g], 0);
      end
      if (!RST_N) ph[g] = 0;
      else case (ph[g])
        0: if (lv[g]) ph[g] = 1;
        1: if (sen[g]) begin
          if (expq[g].size() > 0) void'(expq[g].pop_front());
          if (expq[g].size() == 0) ph[g] = 2;
        end
        default: ph[g] = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // bits[7] is the first bit expected on Q
  task automatic load(input int i, input logic [7:0] w, input bit [7:0] bits);
    int n = 0;
    while (!rdy[i] && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk($sformatf("u%0d_ready_timeout", i), 0, 1);
    for (int k = 7; k >= 0; k--) expq[i].push_back(bits[k]);
    lv[i] = 1'b1;
    d[i] = w;
    tick();
    lv[i] = 1'b0;
    d[i] = 8'($urandom);
  endtask

  // mode 0: strobe every cycle; 1: strobe every other cycle; 2: every cycle with a competing load
  task automatic run(input int i, input int mode);
    int n = 0;
    if (mode == 1) sen[i] = 1'b1;
    while (ph[i] != 0 && n < 60) begin
      sen[i] = (mode == 1) ? !sen[i] : 1'b1;
      if (mode == 2) begin
        lv[i] = expq[i].size() > 2;
        d[i] = 8'hFF;
      end
      tick();
      n++;
    end
    lv[i] = 1'b0;
    if (n >= 60) chk($sformatf("u%0d_run_timeout", i), 0, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      lv[i] = 1'b0;
      sen[i] = 1'b0;
      d[i] = 8'h00;
    end
    #2 RST_N = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 2; i++) begin
        lv[i] = 1'($urandom);
        sen[i] = 1'($urandom);
        d[i] = 8'($urandom);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      lv[i] = 1'b0;
      sen[i] = 1'b0;
    end
    tick();
    RST_N = 1'b1;
    tick();
    sen[0] = 1'b1;
    load(0, 8'hA5, 8'b10100101);
    run(0, 0);
    load(0, 8'h3C, 8'b00111100);
    run(0, 1);
    sen[0] = 1'b1;
    load(0, 8'h0F, 8'b00001111);
    run(0, 2);
    sen[1] = 1'b1;
    load(1, 8'h01, 8'b10000000);
    run(1, 0);
    load(1, 8'hC5, 8'b10100011);
    run(1, 1);
    sen[0] = 1'b1;
    load(0, 8'hA5, 8'b10100101);
    n = 0;
    while (expq[0].size() > 5 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("u0_partial_timeout", 0, 1);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_q", q[0], 0);
    chk("rst_qn", qn[0], 1);
    chk("rst_ready", rdy[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    expq[0].delete();
    ph[0] = 0;
    sen[0] = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    sen[0] = 1'b1;
    load(0, 8'h80, 8'b10000000);
    run(0, 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
